lif_step_scheduler: RTL and testbench
=====================================

Name: lif_step_scheduler

Overview:
- Time-multiplexes one shared LIF update datapath across N_NEURONS neurons.
- Holds all membrane states in a local register array.
- Per accepted time step, updates neurons 0..N-1 one per cycle and collects their spikes into a vector.
- Sits between the input spike/current source and the next layer, replacing N parallel neuron instances with one update unit.

Parameters:
- N_NEURONS, 8, number of neurons sequenced (≥2).
- STATE_W, 8, membrane state width (unsigned).
- CUR_W, 4, per-neuron input current width (unsigned).
- THRESH, 24, spike threshold; a neuron fires when next state ≥ THRESH.
- LEAK_SHIFT, 2, leak = state >> LEAK_SHIFT.
- REFRAC_STEPS, 2, refractory length in time steps (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- step_valid  in  1  request to run one time step.
- step_ready  out  1  scheduler can accept a step.
- cur_vec  in  N_NEURONS*CUR_W  input currents; neuron i uses bits [i*CUR_W +: CUR_W].
- clr  in  1  zero all membrane states (honoured only in IDLE).
- spike_vec  out  N_NEURONS  spikes of the last completed step; bit i belongs to neuron i.
- out_valid  out  1  one-cycle pulse when spike_vec updates.
- busy  out  1  high in RUN or DONE.
- step_cnt  out  16  completed-step counter; wraps 0xFFFF→0.

Behaviour:
- Reset, synchronous, while rst=1: state=IDLE, all membranes=0, spike_vec=0, out_valid=0, busy=0, step_cnt=0, index=0, refractory counters=0. Reset mid-RUN aborts the step with no out_valid.
- FSM IDLE→RUN→DONE→IDLE.
  - step_ready = (state==IDLE) && !clr.
  - IDLE: clr=1 zeroes all membranes and refractory counters next cycle and does not accept a step. step_valid&&step_ready latches cur_vec into a capture register, clears the spike accumulator, sets index=0, and moves to RUN.
  - RUN: each cycle the shared unit updates neuron[index] and writes its state and spike bit. index increments by 1. At index==N_NEURONS-1, moves to DONE.
  - DONE: spike_vec ← accumulator, out_valid=1 for exactly this cycle, step_cnt+1, return to IDLE.
- Latency: acceptance edge to out_valid is N_NEURONS+1 cycles; the next step can be accepted on the cycle after out_valid. Throughput is one step per N_NEURONS+2 cycles.
- cur_vec changes after acceptance have no effect on the running step.
- clr and step_valid in RUN/DONE are ignored and not queued.
- spike_vec holds its value until the next DONE.
- Update arithmetic:
  - sum = state − (state>>LEAK_SHIFT) + cur, computed at STATE_W+1 bits and saturated to 2^STATE_W−1.
  - If sum ≥ THRESH: spike=1 and state←0. Otherwise spike=0 and state←sum.
- No output backpressure; the consumer must take out_valid on the pulse.

Optional Feature:
- Macro LIF_REFRACTORY_EN.
- Defined:
  - Each neuron keeps a refractory counter sized to hold REFRAC_STEPS, loaded with REFRAC_STEPS when it spikes.
  - While its counter is nonzero, the neuron's current is treated as 0 (leak still applies), it cannot spike, and the counter decrements once per processed step.
- Undefined: no counters; current is always applied.

Decomposition:
- Shared package lif_pkg holds:
  - FSM state enum (IDLE, RUN, DONE).
  - Default constants for STATE_W, CUR_W, THRESH, LEAK_SHIFT.
  - Saturating-add width rule.
- One sub-module, lif_update_unit: combinational (state, cur, refractory_active) → (next_state, spike). The scheduler instantiates it once and owns all registers and the FSM.

Test Plan (defaults: N=8, THRESH=24, LEAK_SHIFT=2):
1. Reset, then all currents=15, 4 steps → each neuron follows 15, spike(→0), 15, spike. spike_vec = 0x00, 0xFF, 0x00, 0xFF; step_cnt=4; each out_valid exactly 9 cycles after acceptance.
2. Neuron 3 current=8, others 0, 5 steps → neuron 3 states 8, 14, 19, 23, then spike on step 5. spike_vec=0x08 on step 5 only, 0x00 on steps 1–4.
3. Handshake: hold step_valid during RUN with changing cur_vec → step_ready=0, no extra step, result uses the captured cur_vec. Assert clr together with step_valid in IDLE → states zeroed, step not accepted.
4. Assert rst at the 4th RUN cycle → no out_valid, all states 0, step_cnt unchanged at 0, and the next step behaves as from reset.
5. Force step_cnt to 0xFFFF (run 65535 steps or preload in the bench), one more step → step_cnt=0x0000.
6. LIF_REFRACTORY_EN defined, all currents=15, 6 steps → spike_vec = 0x00, 0xFF, 0x00, 0x00, 0x00, 0xFF (steps 3–4 refractory, state stays 0). Undefined → 0x00, 0xFF, 0x00, 0xFF, 0x00, 0xFF.

Source files
------------

// File: rtl/lif_pkg.sv
// lif_pkg: shared FSM states, default neuron constants and width helpers for the LIF scheduler
package lif_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int STATE_W_D = 8;
  localparam int CUR_W_D = 4;
  localparam int THRESH_D = 24;
  localparam int LEAK_SHIFT_D = 2;
  function automatic int sum_w(input int state_w);
    return state_w + 1;
  endfunction
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/lif_update_unit.sv
// lif_update_unit: combinational leak, saturating integrate and threshold-fire for one neuron
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int STATE_W = STATE_W_D,
  parameter int CUR_W = CUR_W_D,
  parameter int THRESH = THRESH_D,
  parameter int LEAK_SHIFT = LEAK_SHIFT_D
) (
  input  logic [STATE_W-1:0] state,
  input  logic [CUR_W-1:0]   cur,
  input  logic               refractory_active,
  output logic [STATE_W-1:0] next_state,
  output logic               spike
);
  localparam int SW = sum_w(STATE_W);
  logic [STATE_W-1:0] leaked;
  logic [SW-1:0] sum;
  logic [STATE_W-1:0] sat;
  // leak never underflows, so only the add needs the extra carry bit
  always_comb begin
    leaked = state - (state >> LEAK_SHIFT);
    sum = {1'b0, leaked} + SW'(refractory_active ? '0 : cur);
    sat = sum[STATE_W] ? '1 : sum[STATE_W-1:0];
    spike = !refractory_active && ({1'b0, sat} >= SW'(THRESH));
    next_state = spike ? '0 : sat;
  end
endmodule

// File: rtl/lif_step_scheduler.sv
// lif_step_scheduler: one shared LIF unit sweeps N neurons per step; LIF_REFRACTORY_EN adds refractory counters
module lif_step_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int STATE_W = STATE_W_D,
  parameter int CUR_W = CUR_W_D,
  parameter int THRESH = THRESH_D,
  parameter int LEAK_SHIFT = LEAK_SHIFT_D,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       step_valid,
  output logic                       step_ready,
  input  logic [N_NEURONS*CUR_W-1:0] cur_vec,
  input  logic                       clr,
  output logic [N_NEURONS-1:0]       spike_vec,
  output logic                       out_valid,
  output logic                       busy,
  output logic [15:0]                step_cnt
);
  localparam int IDX_W = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1;
  state_t state;
  logic [IDX_W-1:0] idx;
  logic [STATE_W-1:0] mem [N_NEURONS];
  logic [N_NEURONS*CUR_W-1:0] cur_cap;
  logic [N_NEURONS-1:0] acc;
  logic [STATE_W-1:0] nxt;
  logic spk, refr, last;
  assign last = idx == IDX_W'(N_NEURONS - 1);
  assign step_ready = state == IDLE && !clr;
  assign busy = state != IDLE;
  lif_update_unit #(
    .STATE_W(STATE_W),
    .CUR_W(CUR_W),
    .THRESH(THRESH),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_update (
    .state(mem[idx]),
    .cur(cur_cap[idx*CUR_W +: CUR_W]),
    .refractory_active(refr),
    .next_state(nxt),
    .spike(spk)
  );
`ifdef LIF_REFRACTORY_EN
  localparam int RW = cnt_w(REFRAC_STEPS);
  logic [RW-1:0] refr_cnt [N_NEURONS];
  assign refr = refr_cnt[idx] != '0;
  // refractory counters reload on spike and count down once per processed step
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && clr)) begin
      for (int i = 0; i < N_NEURONS; i++) refr_cnt[i] <= '0;
    end else if (state == RUN) begin
      refr_cnt[idx] <= spk ? RW'(REFRAC_STEPS) : refr ? refr_cnt[idx] - 1'b1 : refr_cnt[idx];
    end
  end
`else
  assign refr = REFRAC_STEPS < 0;
`endif
  // step FSM: capture currents, sweep neurons through the shared unit, publish spikes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      cur_cap <= '0;
      spike_vec <= '0;
      out_valid <= 1'b0;
      step_cnt <= '0;
      for (int i = 0; i < N_NEURONS; i++) mem[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            for (int i = 0; i < N_NEURONS; i++) mem[i] <= '0;
          end else if (step_valid) begin
            cur_cap <= cur_vec;
            acc <= '0;
            idx <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          mem[idx] <= nxt;
          acc[idx] <= spk;
          idx <= last ? '0 : idx + 1'b1;
          state <= last ? DONE : RUN;
        end
        DONE: begin
          spike_vec <= acc;
          out_valid <= 1'b1;
          step_cnt <= step_cnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lif_step_scheduler.sv
// tb_lif_step_scheduler: randomized and directed checks of lif_step_scheduler against an integer LIF model
module tb_lif_step_scheduler;
  localparam int N = 8;
  localparam int CW = 4;
  localparam int TH = 24;
  localparam int LS = 2;
  localparam int RS = 2;
  localparam logic [N*CW-1:0] ALL15 = {N{4'hF}};
  localparam logic [N*CW-1:0] ALL12 = {N{4'hC}};
  logic clk = 0, rst = 1, step_valid = 0, clr = 0;
  logic [N*CW-1:0] cur_vec = '0;
  logic step_ready, out_valid, busy;
  logic [N-1:0] spike_vec;
  logic [15:0] step_cnt;
  int checks = 0, errors = 0;
  int m[N];
  int rc[N];
  int mcnt = 0;

  lif_step_scheduler dut (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(step_ready),
    .cur_vec(cur_vec), .clr(clr), .spike_vec(spike_vec), .out_valid(out_valid),
    .busy(busy), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m[i] = 0;
      rc[i] = 0;
    end
  endtask

  function automatic logic [N-1:0] model_step(input logic [N*CW-1:0] cv);
    logic [N-1:0] sp;
    sp = '0;
    for (int i = 0; i < N; i++) begin
      int c, s;
      c = rc[i] > 0 ? 0 : int'(cv[i*CW +: CW]);
      s = m[i] - m[i] / (1 << LS) + c;
      if (s > 255) s = 255;
      if (rc[i] == 0 && s >= TH) begin
        sp[i] = 1'b1;
        m[i] = 0;
`ifdef LIF_REFRACTORY_EN
        rc[i] = RS;
`endif
      end else begin
        m[i] = s;
        if (rc[i] > 0) rc[i] = rc[i] - 1;
      end
    end
    mcnt = (mcnt + 1) % 65536;
    return sp;
  endfunction

  task automatic run_step(input logic [N*CW-1:0] cv, output int lat, output logic [N-1:0] sv);
    logic [N*CW-1:0] r;
    lat = -1;
    @(negedge clk);
    cur_vec = cv;
    step_valid = 1;
    for (int k = 0; k < 20 && !step_ready; k++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    step_valid = 0;
    r = $urandom;
    cur_vec = r;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    sv = spike_vec;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (spike_vec !== '0) begin errors++; $display("FAIL reset_spike_vec got %h exp 00", spike_vec); end
    checks++; if (step_cnt !== 16'h0) begin errors++; $display("FAIL reset_step_cnt got %h exp 0000", step_cnt); end
    @(negedge clk);
    rst = 0;
    model_clear();
    mcnt = 0;
    #1;
    checks++; if (step_ready !== 1'b1) begin errors++; $display("FAIL reset_step_ready got %b exp 1", step_ready); end
  endtask

  task automatic test_all15();
    logic [7:0] tbl [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [N-1:0] sv, ex;
    int lat;
    for (int s = 0; s < 4; s++) begin
      run_step(ALL15, lat, sv);
      ex = model_step(ALL15);
      checks++; if (lat !== 9) begin errors++; $display("FAIL all15_latency step %0d got %0d exp 9", s, lat); end
      checks++; if (sv !== tbl[s] || sv !== ex) begin errors++; $display("FAIL all15_spikes step %0d got %h exp %h", s, sv, tbl[s]); end
    end
    checks++; if (step_cnt !== 16'd4) begin errors++; $display("FAIL all15_step_cnt got %0d exp 4", step_cnt); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL out_valid_pulse got %b exp 0", out_valid); end
  endtask

  task automatic test_single();
    logic [N*CW-1:0] cv;
    logic [N-1:0] sv, ex;
    int lat;
    cv = '0;
    cv[3*CW +: CW] = 4'd8;
    for (int s = 0; s < 5; s++) begin
      run_step(cv, lat, sv);
      ex = model_step(cv);
      checks++; if (sv !== (s == 4 ? 8'h08 : 8'h00) || sv !== ex) begin errors++; $display("FAIL single_spikes step %0d got %h exp %h", s, sv, ex); end
    end
  endtask

  task automatic test_handshake();
    logic [N*CW-1:0] a, r;
    logic [N-1:0] ex, sv;
    int lat, pulses;
    bit bad_ready;
    a = $urandom;
    bad_ready = 0;
    lat = -1;
    @(negedge clk);
    cur_vec = a;
    step_valid = 1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
      if (step_ready !== 1'b0) bad_ready = 1;
      @(negedge clk);
      r = $urandom;
      cur_vec = r;
    end
    sv = spike_vec;
    @(negedge clk);
    step_valid = 0;
    ex = model_step(a);
    checks++; if (bad_ready) begin errors++; $display("FAIL hs_step_ready_busy got 1 exp 0"); end
    checks++; if (sv !== ex || lat !== 9) begin errors++; $display("FAIL hs_captured got %h lat %0d exp %h lat 9", sv, lat, ex); end
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL hs_no_queue got %0d pulses exp 0", pulses); end
    checks++; if (step_cnt !== 16'(mcnt)) begin errors++; $display("FAIL hs_step_cnt got %0d exp %0d", step_cnt, mcnt); end
    run_step(ALL12, lat, sv);
    ex = model_step(ALL12);
    checks++; if (sv !== ex) begin errors++; $display("FAIL hs_pre_clr got %h exp %h", sv, ex); end
    @(negedge clk);
    clr = 1;
    step_valid = 1;
    #1;
    checks++; if (step_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %b exp 0", step_ready); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_accept got busy %b exp 0", busy); end
    @(negedge clk);
    clr = 0;
    step_valid = 0;
    model_clear();
    checks++; if (step_cnt !== 16'(mcnt)) begin errors++; $display("FAIL clr_step_cnt got %0d exp %0d", step_cnt, mcnt); end
    run_step(ALL15, lat, sv);
    ex = model_step(ALL15);
    checks++; if (sv !== ex || sv !== 8'h00) begin errors++; $display("FAIL clr_zeroed got %h exp 00", sv); end
  endtask

  task automatic test_random();
    logic [N*CW-1:0] cv;
    logic [N-1:0] sv, ex;
    int lat;
    for (int s = 0; s < 20; s++) begin
      cv = $urandom;
      run_step(cv, lat, sv);
      ex = model_step(cv);
      checks++; if (sv !== ex) begin errors++; $display("FAIL rand_spikes step %0d got %h exp %h", s, sv, ex); end
      checks++; if (step_cnt !== 16'(mcnt)) begin errors++; $display("FAIL rand_step_cnt step %0d got %0d exp %0d", s, step_cnt, mcnt); end
    end
  endtask

  task automatic test_refractory();
`ifdef LIF_REFRACTORY_EN
    logic [7:0] tbl [6] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
`else
    logic [7:0] tbl [6] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
`endif
    logic [N-1:0] sv, ex;
    int lat;
    test_reset();
    for (int s = 0; s < 6; s++) begin
      run_step(ALL15, lat, sv);
      ex = model_step(ALL15);
      checks++; if (sv !== tbl[s] || sv !== ex) begin errors++; $display("FAIL refrac_spikes step %0d got %h exp %h", s, sv, tbl[s]); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] sv, ex;
    int lat;
    bit saw;
    run_step(ALL15, lat, sv);
    ex = model_step(ALL15);
    @(negedge clk);
    cur_vec = ALL15;
    step_valid = 1;
    @(posedge clk);
    @(negedge clk);
    step_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    saw = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (out_valid) saw = 1;
    end
    @(negedge clk);
    rst = 0;
    model_clear();
    mcnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) saw = 1;
    end
    checks++; if (saw) begin errors++; $display("FAIL midrst_out_valid got 1 exp 0"); end
    checks++; if (step_cnt !== 16'h0) begin errors++; $display("FAIL midrst_step_cnt got %0d exp 0", step_cnt); end
    checks++; if (spike_vec !== '0) begin errors++; $display("FAIL midrst_spike_vec got %h exp 00", spike_vec); end
    run_step(ALL15, lat, sv);
    ex = model_step(ALL15);
    checks++; if (sv !== ex || sv !== 8'h00) begin errors++; $display("FAIL midrst_next got %h exp 00", sv); end
    checks++; if (step_cnt !== 16'd1) begin errors++; $display("FAIL midrst_next_cnt got %0d exp 1", step_cnt); end
  endtask

  task automatic test_wrap();
    logic [N-1:0] sv, ex;
    int lat;
    @(negedge clk);
    force dut.step_cnt = 16'hFFFF;
    #1;
    release dut.step_cnt;
    #1;
    checks++; if (step_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffff", step_cnt); end
    mcnt = 16'hFFFF;
    run_step(ALL15, lat, sv);
    ex = model_step(ALL15);
    checks++; if (step_cnt !== 16'h0000 || step_cnt !== 16'(mcnt)) begin errors++; $display("FAIL wrap_step_cnt got %h exp 0000", step_cnt); end
    checks++; if (sv !== ex) begin errors++; $display("FAIL wrap_spikes got %h exp %h", sv, ex); end
  endtask

  initial begin
    test_reset();
    test_all15();
    test_single();
    test_handshake();
    test_random();
    test_refractory();
    test_reset_mid_run();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
